// File: rtl/sub_bytes_seq_pkg.sv
// aes_pkg: shared AES constants, the forward S-box (and the inverse S-box when
// SUBBYTES_INV_EN is defined), and the SubBytes sequencer state type.
// Macro: SUBBYTES_INV_EN - adds the inverse S-box table and lookup function.
package aes_pkg;

  localparam int unsigned AES_NBYTES = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } fsmState_e;

  // Row r of the table holds S(16r .. 16r+15); the first byte is at the MSB end.
  localparam logic [2047:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] fwdSbox(input logic [7:0] b);
    return SBOX_FWD[(255 - 32'(b)) * 8 +: 8];
  endfunction

`ifdef SUBBYTES_INV_EN
  localparam logic [2047:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] invSbox(input logic [7:0] b);
    return SBOX_INV[(255 - 32'(b)) * 8 +: 8];
  endfunction
`endif

endpackage

// File: rtl/sub_bytes_seq_if.sv
// sub_bytes_seq_if: block handshake bundle for the SubBytes engine.
//   iValid/oReady/iInv/iState : input block handshake, mode and data
//   oValid/iReady/oSubText    : result handshake and data
//   oBusy                     : engine working on or holding a block
// slave = engine side, master = block producer/consumer side.
interface sub_bytes_seq_if;
  logic         iValid;
  logic         oReady;
  logic         iInv;
  logic [127:0] iState;
  logic         oValid;
  logic         iReady;
  logic [127:0] oSubText;
  logic         oBusy;

  modport slave (
    input  iValid, iInv, iState, iReady,
    output oReady, oValid, oSubText, oBusy
  );

  modport master (
    output iValid, iInv, iState, iReady,
    input  oReady, oValid, oSubText, oBusy
  );
endinterface

// File: rtl/sub_bytes_seq_lane.sv
// sbox_lane: combinational single-byte S-box lookup.
//   iMode : 1 = inverse S-box (only with SUBBYTES_INV_EN), 0 = forward
//   iByte : input byte
//   oByte : substituted byte
// Macro: SUBBYTES_INV_EN - without it the lane is forward-only.
module sbox_lane
  import aes_pkg::*;
(
  input  logic       iMode,
  input  logic [7:0] iByte,
  output logic [7:0] oByte
);

`ifdef SUBBYTES_INV_EN
  always_comb oByte = iMode ? invSbox(iByte) : fwdSbox(iByte);
`else
  logic unusedMode;
  assign unusedMode = iMode;
  always_comb oByte = fwdSbox(iByte);
`endif

endmodule

// File: rtl/sub_bytes_seq.sv
// sub_bytes_seq: time-multiplexed AES SubBytes engine. A 128-bit block is
// substituted in place over 16/LANES beats through LANES S-box lanes.
//   iClk, iRsn : clock (rising edge), asynchronous active-low reset
//   bus        : sub_bytes_seq_if.slave (valid/ready in, valid/ready out, oBusy)
// Parameters: LANES (1,2,4,8,16), PIPE (1 = register lane outputs, +1 cycle).
// Macro: SUBBYTES_INV_EN - iInv latched at accept selects the inverse S-box.
module sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned PIPE  = 0
) (
  input  logic           iClk,
  input  logic           iRsn,
  sub_bytes_seq_if.slave bus
);

  localparam int unsigned NBEAT = AES_NBYTES / LANES;
  localparam int unsigned CW    = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam logic [CW-1:0] LAST = CW'(NBEAT - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : gBadLanes
    $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end
  if (PIPE > 1) begin : gBadPipe
    $error("sub_bytes_seq: PIPE must be 0 or 1");
  end

  fsmState_e     fsm;
  logic [CW-1:0] cnt;
  logic [127:0]  stateReg;
  logic          modeReg;
  logic          modeIn;
  logic          validReg, readyReg, busyReg;
  logic [7:0]    laneIn   [LANES];
  logic [7:0]    laneOut  [LANES];
  logic [7:0]    pipeData [LANES];
  logic [CW-1:0] pipeIdx;
  logic          pipeValid;
  int unsigned   beatBase, pipeBase;

`ifdef SUBBYTES_INV_EN
  assign modeIn = bus.iInv;
`else
  logic unusedInv;
  assign unusedInv = bus.iInv;
  assign modeIn    = 1'b0;
`endif

  always_comb begin
    beatBase = 32'(cnt) * LANES;
    pipeBase = 32'(pipeIdx) * LANES;
    for (int unsigned l = 0; l < LANES; l++) begin
      laneIn[l] = stateReg[(beatBase + l) * 8 +: 8];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : gLane
    sbox_lane uLane (
      .iMode (modeReg),
      .iByte (laneIn[g]),
      .oByte (laneOut[g])
    );
  end

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      fsm       <= IDLE;
      cnt       <= '0;
      stateReg  <= '0;
      modeReg   <= 1'b0;
      validReg  <= 1'b0;
      readyReg  <= 1'b1;
      busyReg   <= 1'b0;
      pipeData  <= '{default: '0};
      pipeIdx   <= '0;
      pipeValid <= 1'b0;
    end else begin
      unique case (fsm)
        IDLE: begin
          if (bus.iValid) begin
            stateReg  <= bus.iState;
            modeReg   <= modeIn;
            cnt       <= '0;
            pipeValid <= 1'b0;
            readyReg  <= 1'b0;
            busyReg   <= 1'b1;
            fsm       <= RUN;
          end
        end
        RUN: begin
          if (PIPE == 0) begin
            for (int unsigned l = 0; l < LANES; l++) begin
              stateReg[(beatBase + l) * 8 +: 8] <= laneOut[l];
            end
            if (cnt == LAST) begin
              validReg <= 1'b1;
              fsm      <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            // Issue stage (lanes -> pipeData) runs one beat ahead of write-back;
            // cnt parks at LAST while the final registered beat drains.
            if (pipeValid) begin
              for (int unsigned l = 0; l < LANES; l++) begin
                stateReg[(pipeBase + l) * 8 +: 8] <= pipeData[l];
              end
            end
            if (pipeValid && pipeIdx == LAST) begin
              pipeValid <= 1'b0;
              validReg  <= 1'b1;
              fsm       <= DONE;
            end else begin
              pipeData  <= laneOut;
              pipeIdx   <= cnt;
              pipeValid <= 1'b1;
              if (cnt != LAST) cnt <= cnt + 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.iReady) begin
            validReg <= 1'b0;
            readyReg <= 1'b1;
            busyReg  <= 1'b0;
            fsm      <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign bus.oValid   = validReg;
  assign bus.oReady   = readyReg;
  assign bus.oBusy    = busyReg;
  assign bus.oSubText = stateReg;

endmodule

// File: tb/tb_sub_bytes_seq.sv
module tb_sub_bytes_seq;

  localparam int NCFG = 10;
  localparam int CL [NCFG] = '{4, 1, 1, 2, 2, 4, 8, 8, 16, 16};
  localparam int CP [NCFG] = '{0, 0, 1, 0, 1, 1, 0, 1, 0, 1};
  localparam logic [127:0] VEC2 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] EXP2 = 128'h638293c31bfc33f5c4eeacea4bc12816;

  logic clk = 1'b0;
  logic rsn;
  logic iValid, iInv, iReady;
  logic [127:0] iState;
  logic [NCFG-1:0] sValid, sReady, sBusy;
  logic [127:0] sText [NCFG];

  int nCheck = 0;
  int nPass  = 0;
  logic [7:0] fwdTab [256];
  logic [7:0] invTab [256];

  typedef struct {
    logic [127:0] st;
    logic         inv;
    logic [127:0] exp;
    string        name;
  } vec_t;
  vec_t vecs [5];

  always #5 clk = ~clk;

  for (genvar c = 0; c < NCFG; c++) begin : gDut
    sub_bytes_seq_if bus ();
    sub_bytes_seq #(.LANES(CL[c]), .PIPE(CP[c])) uDut (
      .iClk (clk),
      .iRsn (rsn),
      .bus  (bus.slave)
    );
    assign bus.iValid = iValid;
    assign bus.iInv   = iInv;
    assign bus.iState = iState;
    assign bus.iReady = iReady;
    assign sValid[c]  = bus.oValid;
    assign sReady[c]  = bus.oReady;
    assign sBusy[c]   = bus.oBusy;
    assign sText[c]   = bus.oSubText;
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    nCheck++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  // Reference S-box from its definition: GF(2^8) inverse followed by the affine map.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [7:0] r;
    r = (x << n) | (x >> (8 - n));
    return r;
  endfunction

  task automatic buildTables();
    logic [7:0] inv, a;
    for (int v = 0; v < 256; v++) begin
      a = 8'(v);
      inv = 8'h01;
      if (v == 0) inv = 8'h00;
      else for (int k = 0; k < 254; k++) inv = gmul(inv, a);
      fwdTab[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    for (int v = 0; v < 256; v++) invTab[fwdTab[v]] = 8'(v);
  endtask

  function automatic logic [127:0] modelBlock(input logic [127:0] st, input logic inv);
    logic [127:0] r;
    logic useInv;
`ifdef SUBBYTES_INV_EN
    useInv = inv;
`else
    useInv = 1'b0 & inv;
`endif
    for (int k = 0; k < 16; k++)
      r[8*k +: 8] = useInv ? invTab[st[8*k +: 8]] : fwdTab[st[8*k +: 8]];
    return r;
  endfunction

  task automatic resetChecks(input string tag);
    check({tag, " oValid"}, 128'(sValid), 128'(0));
    check({tag, " oReady"}, 128'(sReady), 128'({NCFG{1'b1}}));
    check({tag, " oBusy"},  128'(sBusy),  128'(0));
    for (int c = 0; c < NCFG; c++) check($sformatf("%s oSubText cfg%0d", tag, c), sText[c], 128'(0));
  endtask

  // Called at a negedge with every engine idle. Mid-block inputs are randomised
  // and must be ignored; the result is then held for 5 cycles with iReady low and
  // handed off while a new block is offered (which must not be taken that cycle).
  task automatic runBlock(input logic [127:0] st, input logic inv, input logic [127:0] exp,
                          input string tag);
    int lat [NCFG];
    check({tag, " idle oReady"}, 128'(sReady), 128'({NCFG{1'b1}}));
    iState = st; iInv = inv; iValid = 1'b1; iReady = 1'b0;
    @(posedge clk);
    foreach (lat[c]) lat[c] = 0;
    @(negedge clk);
    for (int cyc = 1; cyc <= 40; cyc++) begin
      iValid = 1'($urandom_range(0, 1));
      iInv   = 1'($urandom_range(0, 1));
      iState = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk);
      @(negedge clk);
      for (int c = 0; c < NCFG; c++) if (sValid[c] && lat[c] == 0) lat[c] = cyc;
      if (sValid == {NCFG{1'b1}}) break;
    end
    iValid = 1'b0;
    for (int c = 0; c < NCFG; c++) begin
      check($sformatf("%s latency cfg%0d", tag, c), 128'(lat[c]), 128'(16 / CL[c] + CP[c]));
      check($sformatf("%s data cfg%0d", tag, c), sText[c], exp);
    end
    for (int h = 0; h < 5; h++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, " hold oValid"}, 128'(sValid), 128'({NCFG{1'b1}}));
      check({tag, " hold oReady"}, 128'(sReady), 128'(0));
      check({tag, " hold oBusy"},  128'(sBusy),  128'({NCFG{1'b1}}));
      for (int c = 0; c < NCFG; c++) check($sformatf("%s hold data cfg%0d", tag, c), sText[c], exp);
    end
    iValid = 1'b1; iState = ~st; iReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, " handoff oValid"}, 128'(sValid), 128'(0));
    check({tag, " handoff oReady"}, 128'(sReady), 128'({NCFG{1'b1}}));
    check({tag, " no reaccept oBusy"}, 128'(sBusy), 128'(0));
    iValid = 1'b0; iReady = 1'b0;
  endtask

  initial begin
    vecs[0] = '{st: 128'h0, inv: 1'b0, exp: {16{8'h63}}, name: "zero"};
    vecs[1] = '{st: VEC2, inv: 1'b0, exp: EXP2, name: "vec2"};
`ifdef SUBBYTES_INV_EN
    vecs[2] = '{st: {16{8'h63}}, inv: 1'b1, exp: 128'h0, name: "inv63"};
`else
    vecs[2] = '{st: {16{8'h63}}, inv: 1'b1, exp: {16{8'hfb}}, name: "inv63"};
`endif
    vecs[3] = '{st: {16{8'h63}}, inv: 1'b0, exp: {16{8'hfb}}, name: "fwd63"};
    vecs[4] = '{st: {16{8'hff}}, inv: 1'b0, exp: {16{8'h16}}, name: "ones"};

    buildTables();
    rsn = 1'b0; iValid = 1'b0; iInv = 1'b0; iReady = 1'b0; iState = '0;
    repeat (2) @(negedge clk);
    resetChecks("reset");
    rsn = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) runBlock(vecs[i].st, vecs[i].inv, vecs[i].exp, vecs[i].name);

    // Reset pulse during beat 2 of the LANES=4 engine.
    iState = VEC2; iInv = 1'b0; iValid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iValid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rsn = 1'b0;
    #1;
    resetChecks("midrun reset");
    @(negedge clk);
    rsn = 1'b1;
    @(negedge clk);
    runBlock(VEC2, 1'b0, EXP2, "after reset");

    for (int i = 0; i < 8; i++) begin
      logic [127:0] st;
      logic inv;
      st  = {$urandom, $urandom, $urandom, $urandom};
      inv = 1'($urandom_range(0, 1));
      runBlock(st, inv, modelBlock(st, inv), $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", nPass, nCheck);
    $finish;
  end

endmodule
